stepdown_discharge_seq: RTL

Clocked sequencer directly downstream of the step-down discharge path's fixed 1 µs rise-edge delay cell. It consumes that cell's delayed output as a discharge request and drives the discharge switch enable. It monitors a vout-low comparator, qualifies completion over a settle window, and flags a fault on timeout. It reports status to the step-down control logic.

---
 rtl/stepdown_discharge_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/stepdown_discharge_seq.sv
// Step-down discharge sequencer: delayed request -> switch enable, vlow settle qualification, timeout fault.
// Latency: request/release 2 edges after dly_i is sampled; abort_i 1 edge. No backpressure; Moore outputs.
// Optional retry-after-cooldown on the first timeout: define STEPDOWN_DISCHARGE_RETRY_EN.
module stepdown_discharge_seq #(
  parameter int TIMEOUT_CYC = 64,
  parameter int SETTLE_CYC  = 4,
  parameter int CNT_W       = 8
) (
  input  logic CELCLK,
  input  logic CELRST,
  input  logic CELV,
  input  logic CELG,
  input  logic CELSUB,
  input  logic dly_i,
  input  logic vlow_i,
  input  logic abort_i,
  output logic dis_en_o,
  output logic busy_o,
  output logic done_o,
  output logic fault_o
);

  typedef enum logic [2:0] {
    IDLE,
    DISCHARGE,
    SETTLE,
    DONE,
    FAULT
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
    , COOL
`endif
  } state_t;

  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SLAST = CNT_W'(SETTLE_CYC - 1);

  // Power/substrate pins carry no logic.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ CELSUB;

  logic dly_m, dly_s, dly_p;
  logic vlow_m, vlow_s;
  logic rise, fall, timeout;

  state_t state, state_nx;
  logic [CNT_W-1:0] tcnt, tcnt_nx;
  logic [CNT_W-1:0] scnt, scnt_nx;
  state_t tmo_dst;
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
  logic retry, retry_nx;
`endif

  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      dly_m  <= 1'b0;
      dly_s  <= 1'b0;
      dly_p  <= 1'b0;
      vlow_m <= 1'b0;
      vlow_s <= 1'b0;
    end else begin
      dly_m  <= dly_i;
      dly_s  <= dly_m;
      dly_p  <= dly_s;
      vlow_m <= vlow_i;
      vlow_s <= vlow_m;
    end
  end

  assign rise    = dly_s & ~dly_p;
  assign fall    = ~dly_s & dly_p;
  assign timeout = (tcnt == TMAX);

`ifdef STEPDOWN_DISCHARGE_RETRY_EN
  assign tmo_dst = retry ? FAULT : COOL;
`else
  assign tmo_dst = FAULT;
`endif

  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      state <= IDLE;
      tcnt  <= '0;
      scnt  <= '0;
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
      retry <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      tcnt  <= tcnt_nx;
      scnt  <= scnt_nx;
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
      retry <= retry_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    scnt_nx  = scnt;
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
    retry_nx = retry;
`endif
    if (state == IDLE) begin
      tcnt_nx = '0;
      scnt_nx = '0;
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
      retry_nx = 1'b0;
`endif
      if (rise)
        state_nx = DISCHARGE;
    end else if (abort_i || fall) begin
      state_nx = IDLE;
      tcnt_nx  = '0;
      scnt_nx  = '0;
    end else begin
      case (state)
        DISCHARGE: begin
          tcnt_nx = tcnt + 1'b1;
          if (vlow_s && (SETTLE_CYC == 1)) begin
            state_nx = DONE;
          end else if (timeout) begin
            state_nx = tmo_dst;
            scnt_nx  = '0;
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
            retry_nx = 1'b1;
`endif
          end else if (vlow_s) begin
            state_nx = SETTLE;
            scnt_nx  = CNT_W'(1);
          end
        end
        SETTLE: begin
          tcnt_nx = tcnt + 1'b1;
          // Completion outranks a coincident timeout.
          if (vlow_s && (scnt == SLAST)) begin
            state_nx = DONE;
          end else if (timeout) begin
            state_nx = tmo_dst;
            scnt_nx  = '0;
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
            retry_nx = 1'b1;
`endif
          end else if (vlow_s) begin
            scnt_nx = scnt + 1'b1;
          end else begin
            state_nx = DISCHARGE;
            scnt_nx  = '0;
          end
        end
        DONE, FAULT: begin
          if (!dly_s)
            state_nx = IDLE;
        end
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
        COOL: begin
          scnt_nx = scnt + 1'b1;
          if (scnt == SLAST) begin
            state_nx = DISCHARGE;
            tcnt_nx  = '0;
            scnt_nx  = '0;
          end
        end
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  assign dis_en_o = (state == DISCHARGE) || (state == SETTLE);
`ifdef STEPDOWN_DISCHARGE_RETRY_EN
  assign busy_o   = dis_en_o || (state == COOL);
`else
  assign busy_o   = dis_en_o;
`endif
  assign done_o   = (state == DONE);
  assign fault_o  = (state == FAULT);

endmodule
